// File: rtl/adpll_counter_pkg.sv
// adpll_counter_pkg: count-instruction and mode encodings plus a clog2 helper shared by sat_updown_counter.
package adpll_counter_pkg;
  typedef enum logic [1:0] {DISABLE = 2'b00, COUNT_UP = 2'b01, COUNT_DOWN = 2'b10} count_instr_e;
  typedef enum logic {MODE_SAT = 1'b0, MODE_WRAP = 1'b1} count_mode_e;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/leak_timer.sv
// leak_timer: emits a one-cycle tick after PERIOD enabled cycles; present only when SAT_UPDOWN_LEAK_EN is defined.
module leak_timer
  import adpll_counter_pkg::*;
#(
  parameter int PERIOD = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic restart,
  output logic tick
);
  localparam int TW = clog2(PERIOD) + 1;
  localparam logic [TW-1:0] LAST = TW'(PERIOD - 1);
  logic [TW-1:0] t_q, t_d;
  always_comb begin
    tick = enable && !restart && t_q == LAST;
    t_d = (restart || tick) ? '0 : enable ? t_q + 1'b1 : t_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) t_q <= '0;
    else t_q <= t_d;
endmodule

// File: rtl/sat_updown_counter.sv
// sat_updown_counter: signed up/down accumulator with symmetric saturation or wrap, load, limit flags and sticky clamp flag.
// Define SAT_UPDOWN_LEAK_EN to let idle, non-zero counts leak one step toward zero every LEAK_PERIOD cycles.
module sat_updown_counter
  import adpll_counter_pkg::*;
#(
  parameter int WIDTH       = 20,
  parameter int STEP_WIDTH  = 4,
  parameter int LEAK_PERIOD = 256
) (
  input  logic                    fpga_clk_i,
  input  logic                    reset_i,
  input  logic                    clear_i,
  input  logic                    load_i,
  input  logic signed [WIDTH-1:0] load_val_i,
  input  logic [1:0]              count_instr_i,
  input  logic [STEP_WIDTH-1:0]   step_i,
  input  logic [WIDTH-2:0]        limit_i,
  input  logic                    wrap_mode_i,
  input  logic                    sticky_clr_i,
  output logic signed [WIDTH-1:0] counter_val_o,
  output logic                    at_max_o,
  output logic                    at_min_o,
  output logic                    sat_sticky_o
);
  localparam int EW = WIDTH + 2;
  localparam logic signed [EW-1:0] ONE = EW'(1);
  if (LEAK_PERIOD < 1) begin : g_bad_period
    $error("LEAK_PERIOD must be >= 1");
  end
  logic signed [WIDTH-1:0] count_q, count_d;
  logic at_max_q, at_max_d, at_min_q, at_min_d, sticky_q, sticky_d;
  logic signed [EW-1:0] cnt_x, step_x, lim_x, neg_lim_x, load_x, sum_x, base_x, next_x;
  logic up, dn, sat, hi, lo, tick;
  assign up = count_instr_i == COUNT_UP;
  assign dn = count_instr_i == COUNT_DOWN;
  assign sat = wrap_mode_i == MODE_SAT;
`ifdef SAT_UPDOWN_LEAK_EN
  leak_timer #(.PERIOD(LEAK_PERIOD)) u_leak (
    .clk    (fpga_clk_i),
    .rst    (reset_i),
    .enable (!up && !dn && !load_i && !clear_i && count_q != '0),
    .restart(up || dn || load_i || clear_i),
    .tick   (tick)
  );
`else
  assign tick = 1'b0;
`endif
  always_comb begin
    cnt_x     = {{2{count_q[WIDTH-1]}}, count_q};
    step_x    = {{(EW - STEP_WIDTH){1'b0}}, step_i};
    lim_x     = {3'b000, limit_i};
    neg_lim_x = -lim_x;
    load_x    = {{2{load_val_i[WIDTH-1]}}, load_val_i};
    // a leak tick only occurs on idle non-zero counts, so it never crosses zero
    sum_x     = tick ? (cnt_x[EW-1] ? cnt_x + ONE : cnt_x - ONE)
              : up ? cnt_x + step_x : dn ? cnt_x - step_x : cnt_x;
    base_x    = load_i ? load_x : sum_x;
    hi        = sat && base_x > lim_x;
    lo        = sat && base_x < neg_lim_x;
    count_d   = WIDTH'(clear_i ? '0 : hi ? lim_x : lo ? neg_lim_x : base_x);
    next_x    = {{2{count_d[WIDTH-1]}}, count_d};
    at_max_d  = next_x == lim_x;
    at_min_d  = next_x == neg_lim_x;
    sticky_d  = clear_i ? 1'b0 : (hi || lo) ? 1'b1 : sticky_clr_i ? 1'b0 : sticky_q;
  end
  always_ff @(posedge fpga_clk_i or posedge reset_i)
    if (reset_i) {count_q, at_max_q, at_min_q, sticky_q} <= '0;
    else {count_q, at_max_q, at_min_q, sticky_q} <= {count_d, at_max_d, at_min_d, sticky_d};
  assign counter_val_o = count_q;
  assign at_max_o      = at_max_q;
  assign at_min_o      = at_min_q;
  assign sat_sticky_o  = sticky_q;
endmodule

// File: tb/tb_sat_updown_counter.sv
// tb_sat_updown_counter: scoreboard bench; a behavioural integer model queues expected outputs per driven cycle.
module tb_sat_updown_counter;
  localparam int W = 8;
  localparam int SW = 4;
  localparam int LP = 4;
  typedef struct {int cnt; int mx; int mn; int st;} exp_t;
  logic clk = 1'b0, rst = 1'b1, clear = 1'b0, load = 1'b0, wrap = 1'b0, sclr = 1'b0;
  logic signed [W-1:0] load_val = '0;
  logic [1:0] instr = 2'b00;
  logic [SW-1:0] step = '0;
  logic [W-2:0] lim = 7'd100;
  logic signed [W-1:0] cv;
  logic amax, amin, sticky;
  int checks = 0, errors = 0;
  int m_cnt = 0, m_st = 0, m_tmr = 0;
  string tag = "init";
  exp_t exp_q[$];

  sat_updown_counter #(.WIDTH(W), .STEP_WIDTH(SW), .LEAK_PERIOD(LP)) dut (
    .fpga_clk_i(clk), .reset_i(rst), .clear_i(clear), .load_i(load), .load_val_i(load_val),
    .count_instr_i(instr), .step_i(step), .limit_i(lim), .wrap_mode_i(wrap), .sticky_clr_i(sclr),
    .counter_val_o(cv), .at_max_o(amax), .at_min_o(amin), .sat_sticky_o(sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string t, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", t, got, exp);
    end
  endtask

  function automatic int wrap8(input int v);
    return ((v + 128) % 256 + 256) % 256 - 128;
  endfunction

  task automatic model();
    int s, l;
    bit clamp, idle;
    exp_t e;
    l = int'(lim);
    clamp = 0;
    idle = instr != 2'b01 && instr != 2'b10;
    if (clear) begin
      m_cnt = 0; m_st = 0; m_tmr = 0;
    end else begin
      s = load ? int'(load_val) : instr == 2'b01 ? m_cnt + int'(step) : instr == 2'b10 ? m_cnt - int'(step) : m_cnt;
`ifdef SAT_UPDOWN_LEAK_EN
      if (load || !idle) m_tmr = 0;
      else if (m_cnt != 0) begin
        if (m_tmr == LP - 1) begin
          m_tmr = 0;
          s = m_cnt > 0 ? m_cnt - 1 : m_cnt + 1;
        end else m_tmr++;
      end
`endif
      if (!wrap && s > l) begin s = l; clamp = 1; end
      else if (!wrap && s < -l) begin s = -l; clamp = 1; end
      s = wrap8(s);
      m_st = clamp ? 1 : sclr ? 0 : m_st;
      m_cnt = s;
    end
    e.cnt = m_cnt; e.mx = int'(m_cnt == l); e.mn = int'(m_cnt == -l); e.st = m_st;
    exp_q.push_back(e);
  endtask

  task automatic cycle();
    exp_t e;
    model();
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) chk({tag, ".sb_empty"}, 0, 1);
    else begin
      e = exp_q.pop_front();
      chk({tag, ".cnt"}, int'(cv), e.cnt);
      chk({tag, ".max"}, int'(amax), e.mx);
      chk({tag, ".min"}, int'(amin), e.mn);
      chk({tag, ".sticky"}, int'(sticky), e.st);
    end
    @(negedge clk);
    clear = 0; load = 0; sclr = 0; instr = 2'b00; step = '0;
  endtask

  task automatic do_load(input int v);
    load = 1; load_val = W'(v); cycle();
  endtask

  task automatic do_cnt(input logic [1:0] i, input int s, input int n);
    for (int k = 0; k < n; k++) begin
      instr = i; step = SW'(s); cycle();
    end
  endtask

  initial begin
    #2;
    tag = "reset";
    chk("reset.cnt", int'(cv), 0);
    chk("reset.sticky", int'(sticky), 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    tag = "load37"; do_load(37);
    #2 rst = 1;
    #1;
    chk("async_reset.cnt", int'(cv), 0);
    chk("async_reset.max", int'(amax), 0);
    chk("async_reset.min", int'(amin), 0);
    m_cnt = 0; m_st = 0; m_tmr = 0;
    @(negedge clk);
    rst = 0;
    tag = "sat_load98"; do_load(98);
    tag = "sat_up"; do_cnt(2'b01, 7, 1);
    tag = "sat_down"; do_cnt(2'b10, 7, 1);
    tag = "sticky_clr"; sclr = 1; do_cnt(2'b00, 0, 1);
    wrap = 1;
    tag = "wrap_load"; do_load(125);
    tag = "wrap_up"; do_cnt(2'b01, 5, 1);
    wrap = 0;
    tag = "prio_clear"; clear = 1; load = 1; load_val = 8'sd50; instr = 2'b01; step = 4'd3; cycle();
    tag = "load_clamp"; do_load(-120);
    tag = "load80"; clear = 1; cycle(); do_load(80);
    lim = 7'd60;
    tag = "shrink"; do_cnt(2'b00, 0, 1);
    lim = 7'd0;
    tag = "lim0"; do_cnt(2'b00, 0, 1);
    tag = "lim0_up_clr"; sclr = 1; do_cnt(2'b01, 3, 1);
    tag = "instr11"; lim = 7'd127; clear = 1; cycle(); do_load(-127); do_cnt(2'b11, 9, 2);
    tag = "sat_min_down"; do_cnt(2'b10, 15, 1);
    tag = "leave_min"; do_cnt(2'b01, 15, 1);
    tag = "leak3"; lim = 7'd100; clear = 1; cycle(); do_load(3); do_cnt(2'b00, 0, 12);
    tag = "leak_restart"; do_load(3); do_cnt(2'b00, 0, 1); do_cnt(2'b01, 0, 1); do_cnt(2'b00, 0, 6);
    tag = "leak_neg"; do_load(-2); do_cnt(2'b00, 0, 9);
    tag = "rand";
    for (int k = 0; k < 200; k++) begin
      lim = 7'($urandom_range(0, 127));
      wrap = ($urandom_range(0, 3) == 0);
      clear = ($urandom_range(0, 19) == 0);
      load = ($urandom_range(0, 7) == 0);
      load_val = W'($urandom);
      sclr = ($urandom_range(0, 5) == 0);
      instr = 2'($urandom);
      step = SW'($urandom);
      cycle();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
